// File: rtl/mld_pkg.sv
// Shared types, constants and helpers for the serial majority-logic cyclic decoder.
package mld_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        HOLD   = 2'd2
    } mld_state_e;

    // (15,7) code check sums orthogonal on position 14; mask j sits at bits [j*15 +: 15].
    localparam logic [59:0] MLD_15_7_MASKS = {15'h4580, 15'h5808, 15'h6022, 15'h4045};

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

endpackage

// File: rtl/mld_vote.sv
// Evaluates the J orthogonal check sums on the current word and votes on position N-1.
module mld_vote
    import mld_pkg::*;
#(
    parameter int unsigned N      = 15,
    parameter int unsigned J      = 4,
    parameter int unsigned THRESH = J / 2 + 1
) (
    input  logic [N-1:0]   w,
    input  logic [J*N-1:0] chk_mask,
    output logic           fix,
    output logic           votes_zero
);

    localparam int unsigned VW = clog2(J + 1);

    logic [J-1:0]  sums;
    logic [VW-1:0] votes;

    always_comb begin
        sums  = '0;
        votes = '0;
        for (int j = 0; j < J; j++) begin
            sums[j] = ^(w & chk_mask[j*N +: N]);
            votes   = votes + VW'(sums[j]);
        end
    end

    assign fix        = (votes >= VW'(THRESH));
    assign votes_zero = (votes == '0);

endmodule

// File: rtl/mld_cyclic_decoder.sv
// Serial one-step majority-logic decoder for cyclic codes with valid/ready on both sides
// and an optional fast path for words whose first check-sum cycles are all clean.
module mld_cyclic_decoder
    import mld_pkg::*;
#(
    parameter int unsigned N           = 15,
    parameter int unsigned J           = 4,
    parameter              CHK_MASK    = MLD_15_7_MASKS,
    parameter int unsigned THRESH      = J / 2 + 1,
    parameter bit          EARLY_EXIT  = 1'b0,
    parameter int unsigned EXIT_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:N-1]          received_vector,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:N-1]          decoded_vector,
    output logic                  corrected,
    output logic [clog2(N+1)-1:0] num_corr,
    output logic                  busy
);

    localparam int unsigned CW  = clog2(N);
    localparam int unsigned NCW = clog2(N + 1);

    if (THRESH > J) begin : g_bad_thresh
        $error("mld_cyclic_decoder: THRESH must not exceed J");
    end
    if (EXIT_CYCLES < 1 || EXIT_CYCLES >= N) begin : g_bad_exit
        $error("mld_cyclic_decoder: EXIT_CYCLES must be in 1..N-1");
    end
    if ($bits(CHK_MASK) != J * N) begin : g_bad_mask
        $error("mld_cyclic_decoder: CHK_MASK must be J*N bits wide");
    end

    mld_state_e     state_q, state_d;
    logic [N-1:0]   w_q, w_d;
    logic [N-1:0]   orig_q, orig_d;
    logic [N-1:0]   dec_q, dec_d;
    logic [N-1:0]   rx, w_shift;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NCW-1:0] num_corr_d;
    logic           zero_run_q, zero_run_d;
    logic           corrected_d;
    logic           fix, votes_zero;

    // Internal vectors use bit p = code position p; ports are declared ascending.
    always_comb begin
        for (int p = 0; p < N; p++) begin
            rx[p]             = received_vector[p];
            decoded_vector[p] = dec_q[p];
        end
    end

    mld_vote #(
        .N      (N),
        .J      (J),
        .THRESH (THRESH)
    ) u_vote (
        .w          (w_q),
        .chk_mask   (CHK_MASK),
        .fix        (fix),
        .votes_zero (votes_zero)
    );

    // Correct position N-1, then rotate it down to position 0.
    assign w_shift = {w_q[N-2:0], w_q[N-1] ^ fix};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        orig_d      = orig_q;
        cnt_d       = cnt_q;
        zero_run_d  = zero_run_q;
        num_corr_d  = num_corr;
        dec_d       = dec_q;
        corrected_d = corrected;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    w_d        = rx;
                    orig_d     = rx;
                    cnt_d      = '0;
                    num_corr_d = '0;
                    zero_run_d = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                w_d        = w_shift;
                num_corr_d = num_corr + NCW'(fix);
                zero_run_d = zero_run_q & votes_zero;
                cnt_d      = cnt_q + CW'(1);
                if (EARLY_EXIT && (cnt_q == CW'(EXIT_CYCLES - 1)) && zero_run_d) begin
                    cnt_d       = cnt_q;
                    dec_d       = orig_q;
                    corrected_d = 1'b0;
                    num_corr_d  = '0;
                    state_d     = HOLD;
                end else if (cnt_q == CW'(N - 1)) begin
                    cnt_d       = cnt_q;
                    dec_d       = w_shift;
                    corrected_d = (num_corr_d != '0);
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_q        <= '0;
            orig_q     <= '0;
            dec_q      <= '0;
            cnt_q      <= '0;
            zero_run_q <= 1'b0;
            num_corr   <= '0;
            corrected  <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            w_q        <= w_d;
            orig_q     <= orig_d;
            dec_q      <= dec_d;
            cnt_q      <= cnt_d;
            zero_run_q <= zero_run_d;
            num_corr   <= num_corr_d;
            corrected  <= corrected_d;
            in_ready   <= (state_d == IDLE);
            out_valid  <= (state_d == HOLD);
            busy       <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_mld_cyclic_decoder.sv
// Scoreboard bench for mld_cyclic_decoder: one instance on the full path, one with early exit.
module tb_mld_cyclic_decoder;

    localparam int unsigned N = 15;

    typedef struct {
        logic [0:N-1] dec;
        logic         corr;
        logic [3:0]   nc;
        int           lat;
        int           t_acc;
    } exp_t;

    // Hand-built words; literal MSB is code position 0.
    localparam logic [0:N-1] G   = 15'b100010111000000;  // g(x): positions 0,4,6,7,8
    localparam logic [0:N-1] G2E = 15'b101010111010000;  // g(x) + errors at 2,10
    localparam logic [0:N-1] G5E = 15'b100011111000000;  // g(x) + error at 5
    localparam logic [0:N-1] Z   = 15'b000000000000000;
    localparam logic [0:N-1] E14 = 15'b000000000000001;  // zero word + error at 14
    localparam logic [0:N-1] Z39 = 15'b000100000100000;  // zero word + errors at 3,9
    localparam logic [0:N-1] XG  = 15'b010001011100000;  // x*g(x): positions 1,5,7,8,9
    localparam logic [0:N-1] XG7 = 15'b010001001100000;  // x*g(x) + error at 7

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         iv   [2];
    logic         ir   [2];
    logic         ov   [2];
    logic         ordy [2];
    logic         corr [2];
    logic         bsy  [2];
    logic [0:N-1] rx   [2];
    logic [0:N-1] dec  [2];
    logic [3:0]   nc   [2];

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mld_cyclic_decoder #(.N(N), .J(4), .EARLY_EXIT(1'b0), .EXIT_CYCLES(3)) u_dut0 (
        .clk(clk), .reset(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .received_vector(rx[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .decoded_vector(dec[0]),
        .corrected(corr[0]), .num_corr(nc[0]), .busy(bsy[0])
    );

    mld_cyclic_decoder #(.N(N), .J(4), .EARLY_EXIT(1'b1), .EXIT_CYCLES(3)) u_dut1 (
        .clk(clk), .reset(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .received_vector(rx[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .decoded_vector(dec[1]),
        .corrected(corr[1]), .num_corr(nc[1]), .busy(bsy[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns #1 after the accepting posedge.
    task automatic send(input int d, input logic [0:N-1] word, input bit track,
                        input logic [0:N-1] e_dec, input logic e_c, input logic [3:0] e_nc,
                        input int lat);
        exp_t e;
        int   n;
        iv[d] = 1'b1;
        rx[d] = word;
        n     = 0;
        while (!ir[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("dut%0d accept_wait", d), 32'(n < 100), 32'd1);
        e.dec   = e_dec;
        e.corr  = e_c;
        e.nc    = e_nc;
        e.lat   = lat;
        e.t_acc = cyc + 1;
        if (track) begin
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((((d == 0) ? q0.size() : q1.size()) != 0 || ov[d]) && n < 200);
        chk($sformatf("dut%0d drain", d), 32'(n < 200), 32'd1);
    endtask

    // Monitor: pop on each rising out_valid, check stability while held.
    initial begin : monitor
        logic ov_prev [2];
        exp_t last    [2];
        exp_t e;
        bit   have;
        ov_prev[0] = 1'b0;
        ov_prev[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (ov[d] && !ov_prev[d]) begin
                    have = 1'b0;
                    if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    chk($sformatf("dut%0d expected_pending", d), 32'(have), 32'd1);
                    if (have) begin
                        chk($sformatf("dut%0d decoded", d),   32'(dec[d]),        32'(e.dec));
                        chk($sformatf("dut%0d corrected", d), 32'(corr[d]),       32'(e.corr));
                        chk($sformatf("dut%0d num_corr", d),  32'(nc[d]),         32'(e.nc));
                        chk($sformatf("dut%0d latency", d),   32'(cyc - e.t_acc), 32'(e.lat));
                        last[d] = e;
                    end
                end else if (ov[d] && ov_prev[d]) begin
                    chk($sformatf("dut%0d hold_decoded", d),  32'(dec[d]),  32'(last[d].dec));
                    chk($sformatf("dut%0d hold_num_corr", d), 32'(nc[d]),   32'(last[d].nc));
                    chk($sformatf("dut%0d hold_corrected", d), 32'(corr[d]), 32'(last[d].corr));
                end
                if (ov[d]) chk($sformatf("dut%0d in_ready_in_hold", d), 32'(ir[d]), 32'd0);
                ov_prev[d] = ov[d];
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        for (int d = 0; d < 2; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b1;
            rx[d]   = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d rst_in_ready", d),  32'(ir[d]),   32'd1);
            chk($sformatf("dut%0d rst_out_valid", d), 32'(ov[d]),   32'd0);
            chk($sformatf("dut%0d rst_busy", d),      32'(bsy[d]),  32'd0);
            chk($sformatf("dut%0d rst_num_corr", d),  32'(nc[d]),   32'd0);
            chk($sformatf("dut%0d rst_corrected", d), 32'(corr[d]), 32'd0);
            chk($sformatf("dut%0d rst_decoded", d),   32'(dec[d]),  32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Full path
        send(0, G,   1'b1, G,  1'b0, 4'd0, 15); drain(0);
        send(0, G2E, 1'b1, G,  1'b1, 4'd2, 15); drain(0);
        send(0, E14, 1'b1, Z,  1'b1, 4'd1, 15); drain(0);
        send(0, Z39, 1'b1, Z,  1'b1, 4'd2, 15); drain(0);
        send(0, XG7, 1'b1, XG, 1'b1, 4'd1, 15); drain(0);

        // Early-exit instance
        send(1, G,   1'b1, G,  1'b0, 4'd0, 3);  drain(1);
        send(1, Z,   1'b1, Z,  1'b0, 4'd0, 3);  drain(1);
        send(1, G5E, 1'b1, G,  1'b1, 4'd1, 15); drain(1);

        // Backpressure with a second word waiting
        ordy[0] = 1'b0;
        @(negedge clk);
        send(0, G2E, 1'b1, G, 1'b1, 4'd2, 15);
        n = 0;
        while (!ov[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("dut0 bp_out_valid_wait", 32'(n < 100), 32'd1);
        iv[0] = 1'b1;
        rx[0] = E14;
        repeat (5) begin
            @(negedge clk);
            chk("dut0 bp_in_ready", 32'(ir[0]),  32'd0);
            chk("dut0 bp_out_valid", 32'(ov[0]), 32'd1);
            chk("dut0 bp_busy", 32'(bsy[0]),     32'd1);
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("dut0 bp_release_out_valid", 32'(ov[0]),  32'd0);
        chk("dut0 bp_release_in_ready",  32'(ir[0]),  32'd1);
        chk("dut0 bp_release_busy",      32'(bsy[0]), 32'd0);
        send(0, E14, 1'b1, Z, 1'b1, 4'd1, 15); drain(0);

        // Reset in the middle of a decode; that word must never appear
        send(0, G2E, 1'b0, Z, 1'b0, 4'd0, 0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("dut0 midrst_out_valid", 32'(ov[0]),  32'd0);
        chk("dut0 midrst_in_ready",  32'(ir[0]),  32'd1);
        chk("dut0 midrst_busy",      32'(bsy[0]), 32'd0);
        chk("dut0 midrst_num_corr",  32'(nc[0]),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, G5E, 1'b1, G, 1'b1, 4'd1, 15); drain(0);

        @(negedge clk);
        chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mld_cyclic_decoder.md
Name: mld_cyclic_decoder

Overview:
- Parametrised serial one-step majority-logic decoder for cyclic codes; generalises the fixed (15,7) decoder to any length N with J orthogonal check sums.
- Latches a received word and, once per clock, votes on position N-1, corrects it and cyclically shifts the word. After N shifts the word is back in its original alignment.
- Adds a valid/ready handshake on both sides, correction reporting, and an optional early-exit mode that skips decoding of error-free words.
- Sits between the channel/demodulator buffer and the data sink in the decoder chain.

Parameters:
- N, 15: code length in bits.
- J, 4: number of check sums orthogonal on position N-1.
- CHK_MASK, MLD_15_7_MASKS: J*N-bit concatenation of check-sum masks. Mask j occupies bits [j*N +: N]; bit p of a mask selects word position p.
- THRESH, J/2+1: votes required to flip position N-1.
- EARLY_EXIT, 0: 1 enables the error-free fast path.
- EXIT_CYCLES, 3: number of initial cycles that must show all-zero check sums before the fast path is taken. Legal range 1..N-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  received_vector is valid.
- in_ready  out  1  block can accept a word.
- received_vector  in  [0:N-1]  received word; index = code position.
- out_valid  out  1  decoded_vector is valid.
- out_ready  in  1  sink accepts the output.
- decoded_vector  out  [0:N-1]  corrected word, original alignment.
- corrected  out  1  at least one bit was flipped for this word.
- num_corr  out  [$clog2(N+1)-1:0]  number of bits flipped.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0.
  - decoded_vector=0, corrected=0, num_corr=0, cnt=0.
  - Any decode in progress is discarded and produces no output.
- States: IDLE, DECODE, HOLD.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - load working register w and shadow copy orig from received_vector;
  - cnt=0, num_corr=0, zero_run=1;
  - go to DECODE.
- DECODE: in_ready=0. Each cycle:
  - s_j = XOR over p of (w[p] & mask_j[p]); votes = count of s_j=1.
  - fix = (votes >= THRESH).
  - Next w = cyclic shift of (w with w[N-1]^=fix): new[0]=old[N-1]^fix, new[p]=old[p-1] for p in 1..N-1.
  - num_corr += fix; cnt += 1; zero_run &= (votes==0).
  - When cnt reaches N-1 (the N-th shift): decoded_vector = next w, corrected = (next num_corr != 0), go to HOLD.
  - Early exit: if EARLY_EXIT=1, cnt==EXIT_CYCLES-1, and zero_run stays 1 after this cycle, then decoded_vector=orig, corrected=0, num_corr=0, go to HOLD.
- HOLD: out_valid=1. Outputs stay stable until out_ready=1; on that edge out_valid=0 and state returns to IDLE.
  - in_ready=0 in HOLD, so there is no overlap between words.
  - out_ready while out_valid=0 is ignored.
- Latency, from the accepting edge to out_valid rising: N cycles normal path, EXIT_CYCLES cycles on the fast path. Throughput is one word per N+2 cycles at best (accept edge, N DECODE cycles, HOLD/handshake).
- Correction capability: up to floor(J/2) errors. Beyond that the output is undefined but the handshake and timing are unchanged. There is no uncorrectable-error detection.
- Arithmetic widths:
  - votes is $clog2(J+1) bits;
  - cnt is $clog2(N) bits and never wraps (exit condition at N-1);
  - num_corr saturation is not needed (at most N).
- Elaboration assertions: THRESH <= J, 1 <= EXIT_CYCLES < N, $bits(CHK_MASK) == J*N.

Decomposition:
- Package mld_pkg holds:
  - the MLD_15_7_MASKS constant: sets {14,0,2,6}, {14,13,1,5}, {14,11,12,3}, {14,7,8,10};
  - a state enum for IDLE/DECODE/HOLD;
  - a clog2 helper.
- One sub-module, mld_vote: combinational J check-sum evaluation plus popcount/threshold. Inputs w and CHK_MASK; outputs fix and votes_zero.
- FSM, registers and counters live in mld_cyclic_decoder.

Test Plan:
- Clean codeword g(x): received 15'b100010111000000 (positions 0,4,6,7,8 set), EARLY_EXIT=0 -> out_valid 15 cycles after accept; decoded equals input; corrected=0; num_corr=0.
- Same word with errors at positions 2 and 10 -> decoded 15'b100010111000000, corrected=1, num_corr=2.
- Single error at position 14 on the all-zero word -> decoded all zeros; num_corr=1.
- EARLY_EXIT=1, EXIT_CYCLES=3, clean g(x) -> out_valid 3 cycles after accept, decoded equals input. Repeat with one error at position 5 -> full 15-cycle path, num_corr=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0, a second in_valid is not accepted. Set out_ready=1 -> IDLE next cycle, then the second word is accepted.
- Reset low at cycle 7 of DECODE -> out_valid=0, in_ready=1, busy=0 immediately. After release, a fresh word decodes correctly with no stale output.
